// File: rtl/flag_dispense.sv
// Byte buffer between capture and LEDs: stores written bytes in a circular store and shows
// one per debounced BTNR press, oldest first; BTNC clears buffer, display and sticky flags.
module flag_dispense #(
    parameter int DEPTH = 38,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          BTNR,
    input  logic          BTNC,
    output logic [7:0]    disp,
    output logic          disp_valid,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          udf
);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_UNDER} state_t;

    logic          btnr_meta_q, btnr_meta_d, btnr_sync_q, btnr_sync_d, btnr_prev_q, btnr_prev_d;
    logic          btnc_meta_q, btnc_meta_d, btnc_sync_q, btnc_sync_d, btnc_prev_q, btnc_prev_d;
    logic          step_q, step_d, clr_q, clr_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [7:0]    disp_q, disp_d;
    logic          disp_valid_q, disp_valid_d, ovf_q, ovf_d, udf_q, udf_d;
    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic          mem_we, rd_acc, empty_w, full_w;

    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
        return (p == CW'(DEPTH - 1)) ? '0 : p + CW'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));

    always_comb begin
        btnr_meta_d  = BTNR;
        btnr_sync_d  = btnr_meta_q;
        btnr_prev_d  = btnr_sync_q;
        step_d       = btnr_sync_q & ~btnr_prev_q;
        btnc_meta_d  = BTNC;
        btnc_sync_d  = btnc_meta_q;
        btnc_prev_d  = btnc_sync_q;
        clr_d        = btnc_sync_q & ~btnc_prev_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        disp_d       = disp_q;
        disp_valid_d = disp_valid_q;
        ovf_d        = ovf_q;
        udf_d        = udf_q;
        state_d      = state_q;
        mem_we       = 1'b0;
        rd_acc       = 1'b0;
        if (clr_q) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            disp_d       = '0;
            disp_valid_d = 1'b0;
            ovf_d        = 1'b0;
            udf_d        = 1'b0;
            state_d      = S_IDLE;
        end else begin
            // full/empty are judged on the pre-edge count, so no bypass either way
            if (wr_en) begin
                if (full_w) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
            end
            if (step_q) begin
                if (empty_w) begin
                    udf_d   = 1'b1;
                    state_d = S_UNDER;
                end else begin
                    rd_acc       = 1'b1;
                    disp_d       = mem_q[rd_ptr_q];
                    rd_ptr_d     = ptr_inc(rd_ptr_q);
                    disp_valid_d = 1'b1;
                    state_d      = S_SHOW;
                end
            end
            count_d = count_q + (mem_we ? CW'(1) : CW'(0)) - (rd_acc ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btnr_meta_q  <= 1'b0;
            btnr_sync_q  <= 1'b0;
            btnr_prev_q  <= 1'b0;
            btnc_meta_q  <= 1'b0;
            btnc_sync_q  <= 1'b0;
            btnc_prev_q  <= 1'b0;
            step_q       <= 1'b0;
            clr_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            disp_q       <= '0;
            disp_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
            state_q      <= S_IDLE;
        end else begin
            btnr_meta_q  <= btnr_meta_d;
            btnr_sync_q  <= btnr_sync_d;
            btnr_prev_q  <= btnr_prev_d;
            btnc_meta_q  <= btnc_meta_d;
            btnc_sync_q  <= btnc_sync_d;
            btnc_prev_q  <= btnc_prev_d;
            step_q       <= step_d;
            clr_q        <= clr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            disp_q       <= disp_d;
            disp_valid_q <= disp_valid_d;
            ovf_q        <= ovf_d;
            udf_q        <= udf_d;
            state_q      <= state_d;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign disp       = disp_q;
    assign disp_valid = disp_valid_q;
    assign count      = count_q;
    assign empty      = empty_w;
    assign full       = full_w;
    assign ovf        = ovf_q;
    assign udf        = udf_q;

endmodule

// File: tb/tb_flag_dispense.sv
// Randomized and directed bench for flag_dispense against a queue-based reference model.
module tb_flag_dispense;

    localparam int DEPTH = 38;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          BTNR;
    logic          BTNC;
    logic [7:0]    disp;
    logic          disp_valid;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;

    flag_dispense #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .BTNR(BTNR), .BTNC(BTNC),
        .disp(disp), .disp_valid(disp_valid), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] m_disp;
    logic       m_valid, m_ovf, m_udf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_disp  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // One clock edge of behaviour: stp/cl mean a step/clear pulse is acting on this edge
    task automatic model_edge(input bit wr, input logic [7:0] d, input bit stp, input bit cl);
        int  pre_n;
        if (cl) begin
            model_reset();
            return;
        end
        pre_n = mq.size();
        if (stp) begin
            if (pre_n == 0) begin
                m_udf = 1'b1;
            end else begin
                m_disp  = mq.pop_front();
                m_valid = 1'b1;
            end
        end
        if (wr) begin
            if (pre_n == DEPTH) m_ovf = 1'b1;
            else mq.push_back(d);
        end
    endtask

    task automatic compare_all();
        check("count", 32'(count), 32'(mq.size()));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("disp", 32'(disp), 32'(m_disp));
        check("disp_valid", 32'(disp_valid), 32'(m_valid));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
    endtask

    // Called at posedge+1; drives inputs for the next edge, then checks after it
    task automatic tick(input bit wr, input logic [7:0] d, input bit stp, input bit cl);
        wr_en   = wr;
        wr_data = d;
        @(posedge clk);
        model_edge(wr, d, stp, cl);
        #1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        compare_all();
    endtask

    // Button held for 'hold' edges; its pulse acts on the 4th edge after the pin rises
    task automatic press(input bit is_clr, input int hold, input bit wr_at, input logic [7:0] d);
        if (is_clr) BTNC = 1'b1;
        else        BTNR = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(wr_at, d, !is_clr, is_clr);
        for (int i = 4; i < hold; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        BTNR = 1'b0;
        BTNC = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr_byte(input logic [7:0] d);
        tick(1'b1, d, 1'b0, 1'b0);
    endtask

    string flag_s;

    initial begin
        flag_s  = "flag{b1t5_1n_th3_buff3r_f1f0_0rd3r_ok}";
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        BTNR    = 1'b0;
        BTNC    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("rst_empty", 32'(empty), 32'd1);
        rst = 1'b0;

        // 1: full flag string in, then out in the same order
        for (int i = 0; i < DEPTH; i++) wr_byte(flag_s[i]);
        check("t1_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            press(1'b0, 4, 1'b0, 8'h00);
            check("t1_order", 32'(disp), 32'(flag_s[i]));
        end
        check("t1_empty", 32'(empty), 32'd1);

        // 2+3: overflow drops 39th byte; press on empty keeps last byte '}'
        for (int i = 0; i < DEPTH; i++) wr_byte(flag_s[i]);
        wr_byte(8'hAA);
        check("t2_ovf", 32'(ovf), 32'd1);
        check("t2_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) press(1'b0, 5, 1'b0, 8'h00);
        check("t2_last", 32'(disp), 32'h7D);
        press(1'b0, 4, 1'b0, 8'h00);
        check("t3_disp", 32'(disp), 32'h7D);
        check("t3_valid", 32'(disp_valid), 32'd1);
        check("t3_udf", 32'(udf), 32'd1);

        // 4: wrap-around of write pointer
        press(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) wr_byte(8'(i));
        for (int i = 0; i < 10; i++) press(1'b0, 4, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) wr_byte(8'(8'h80 + i));
        for (int i = 0; i < DEPTH; i++) press(1'b0, 4, 1'b0, 8'h00);
        check("t4_last", 32'(disp), 32'h89);

        // 5: write coinciding with step, non-empty then empty
        press(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) wr_byte(8'(8'h40 + i));
        press(1'b0, 4, 1'b1, 8'h55);
        check("t5_count", 32'(count), 32'd5);
        check("t5_disp", 32'(disp), 32'h40);
        for (int i = 0; i < 5; i++) press(1'b0, 4, 1'b0, 8'h00);
        press(1'b0, 4, 1'b1, 8'h66);
        check("t5_udf", 32'(udf), 32'd1);
        check("t5_count0", 32'(count), 32'd1);
        check("t5_disp0", 32'(disp), 32'h55);
        // full plus step: slot frees but write still dropped
        press(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < DEPTH; i++) wr_byte(8'(i + 3));
        press(1'b0, 4, 1'b1, 8'hEE);
        check("t5_fullstep_ovf", 32'(ovf), 32'd1);
        check("t5_fullstep_cnt", 32'(count), 32'(DEPTH - 1));

        // 6: long hold gives one dispense; async reset mid-fill; clear button
        press(1'b0, 100, 1'b0, 8'h00);
        check("t6_hold_cnt", 32'(count), 32'(DEPTH - 2));
        press(1'b1, 4, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) wr_byte(8'(i + 8'h20));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_disp", 32'(disp), 32'd0);
        check("t6_rst_flags", 32'({disp_valid, ovf, udf, full}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) wr_byte(8'(i + 8'h30));
        press(1'b0, 4, 1'b0, 8'h00);
        press(1'b1, 6, 1'b0, 8'h00);
        check("t6_clr_count", 32'(count), 32'd0);
        check("t6_clr_disp", 32'(disp), 32'd0);

        // randomized mix
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10)       wr_byte(8'($urandom));
            else if (r < 18)  press(1'b0, $urandom_range(4, 7), 1'($urandom_range(0, 1)), 8'($urandom));
            else if (r == 18) press(1'b1, 4, 1'($urandom_range(0, 1)), 8'($urandom));
            else              tick(1'b0, 8'h00, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
